// File: rtl/otn_pkg.sv
// +----------------------------------------------------------------------+
// | otn_pkg : shared OTN framing constants, receiver state encoding       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package otn_pkg;

  localparam int OTN_FRAME_LEN = 4164;
  localparam int OTN_BAUD_DIV  = 20;
  localparam int OTN_FAS_LEN   = 6;

  // Byte 0 of the alignment word sits in bits [7:0]; bits arrive LSB first.
  localparam logic [47:0] OTN_FAS = 48'h2828_28F6_F6F6;

  // Sender-side constants
  localparam int         OTN_ACK_SYMBOLS = 3;
  localparam logic       OTN_LINE_IDLE   = 1'b1;
  localparam int         OTN_TX_ACK_WAIT = 4 * OTN_BAUD_DIV * OTN_ACK_SYMBOLS;

  typedef enum logic [2:0] {
    ST_HUNT      = 3'd0,
    ST_RECEIVE   = 3'd1,
    ST_CHECK     = 3'd2,
    ST_ACK_START = 3'd3,
    ST_ACK_BIT   = 3'd4,
    ST_ACK_STOP  = 3'd5
  } rx_state_t;

  function automatic logic [7:0] fas_byte(input logic [2:0] idx);
    logic [47:0] w_sh;
    w_sh = OTN_FAS >> {idx, 3'b000};
    return w_sh[7:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rx_bit_sampler.sv
// +----------------------------------------------------------------------+
// | rx_bit_sampler : input synchronizer, edge-aligned phase counter, and  |
// | mid-bit sampler. Rev 1.0                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rx_bit_sampler
  import otn_pkg::*;
#(
  parameter int BAUD_DIV = OTN_BAUD_DIV
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sclk_en_16_x_baud,
  input  logic i_rx,
  output logic o_bit,
  output logic o_bit_strobe
);

  localparam int                CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0]     C_LAST   = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0]     C_SAMPLE = CW'(BAUD_DIV / 2 - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic [CW-1:0] r_phase;
  logic          r_bit;
  logic          r_strobe;
  logic          w_edge;

  assign w_edge = r_sync2 ^ r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_prev   <= 1'b0;
      r_phase  <= '0;
      r_bit    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_sync1  <= i_rx;
      r_sync2  <= r_sync1;
      r_prev   <= r_sync2;
      r_strobe <= 1'b0;
      // A line transition re-centres the sample point on the new bit.
      if (w_edge) begin
        r_phase <= '0;
      end else if (i_sclk_en_16_x_baud) begin
        r_phase <= (r_phase == C_LAST) ? '0 : r_phase + 1'b1;
        if (r_phase == C_SAMPLE) begin
          r_bit    <= r_sync2;
          r_strobe <= 1'b1;
        end
      end
    end
  end

  assign o_bit        = r_bit;
  assign o_bit_strobe = r_strobe;

endmodule

`default_nettype wire

// File: rtl/frame_rx_ack.sv
// +----------------------------------------------------------------------+
// | frame_rx_ack : FAS hunt, byte deserializer, BIP-8 check, serial ACK.  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module frame_rx_ack
  import otn_pkg::*;
#(
  parameter int FRAME_LEN = OTN_FRAME_LEN,
  parameter int BAUD_DIV  = OTN_BAUD_DIV
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sclk_en_16_x_baud,
  input  logic       i_otn_rx_data,
  input  logic       i_arq_en,
  output logic [7:0] o_data,
  output logic       o_data_valid,
  output logic       o_frame_start,
  output logic       o_frame_good,
  output logic       o_frame_bad,
  output logic       o_otn_tx_ack,
  output logic       o_locked
);

  localparam int             TCW         = $clog2(BAUD_DIV);
  localparam logic [TCW-1:0] C_TX_LAST   = TCW'(BAUD_DIV - 1);
  localparam logic [12:0]    C_LAST_BYTE = 13'(FRAME_LEN - 1);
  localparam logic [2:0]     C_FAS_LAST  = 3'(OTN_FAS_LEN - 1);

  logic           w_bit;
  logic           w_strobe;

  rx_state_t      r_state;
  rx_state_t      w_state_next;

  logic [47:0]    r_hunt;
  logic [47:0]    w_hunt_shift;
  logic [2:0]     r_bitcnt;
  logic [12:0]    r_byte_cnt;
  logic [2:0]     r_fas_idx;
  logic           r_fas_busy;
  logic [7:0]     r_bip;
  logic           r_match;
  logic [TCW-1:0] r_tx_cnt;

  logic [7:0]     r_data;
  logic           r_data_valid;
  logic           r_frame_start;
  logic           r_frame_good;
  logic           r_frame_bad;
  logic           r_tx_ack;
  logic           r_locked;

  logic           w_fas_hit;
  logic           w_byte_done;
  logic           w_last_byte;
  logic [7:0]     w_byte;
  logic           w_tx_wrap;
  logic           w_in_ack;
  logic           w_tx_ack_next;

  rx_bit_sampler #(
    .BAUD_DIV (BAUD_DIV)
  ) u_sampler (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_sclk_en_16_x_baud (i_sclk_en_16_x_baud),
    .i_rx                (i_otn_rx_data),
    .o_bit               (w_bit),
    .o_bit_strobe        (w_strobe)
  );

  assign w_hunt_shift = {w_bit, r_hunt[47:1]};
  assign w_byte       = w_hunt_shift[47:40];
  assign w_fas_hit    = (r_state == ST_HUNT) && (r_hunt == OTN_FAS);
  assign w_byte_done  = (r_state == ST_RECEIVE) && w_strobe && (r_bitcnt == 3'd7);
  assign w_last_byte  = w_byte_done && (r_byte_cnt == C_LAST_BYTE);
  assign w_in_ack     = (r_state == ST_ACK_START) || (r_state == ST_ACK_BIT) ||
                        (r_state == ST_ACK_STOP);
  assign w_tx_wrap    = i_sclk_en_16_x_baud && (r_tx_cnt == C_TX_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_HUNT:      if (w_fas_hit)   w_state_next = ST_RECEIVE;
      ST_RECEIVE:   if (w_last_byte) w_state_next = ST_CHECK;
      ST_CHECK:     w_state_next = i_arq_en ? ST_ACK_START : ST_HUNT;
      ST_ACK_START: if (w_tx_wrap)   w_state_next = ST_ACK_BIT;
      ST_ACK_BIT:   if (w_tx_wrap)   w_state_next = ST_ACK_STOP;
      ST_ACK_STOP:  if (w_tx_wrap)   w_state_next = ST_HUNT;
      default:      w_state_next = ST_HUNT;
    endcase
  end

  // ACK line follows the state being entered so its level and the state change together.
  always_comb begin
    w_tx_ack_next = 1'b1;
    case (w_state_next)
      ST_ACK_START: w_tx_ack_next = 1'b0;
      ST_ACK_BIT:   w_tx_ack_next = r_match;
      ST_ACK_STOP:  w_tx_ack_next = 1'b0;
      default:      w_tx_ack_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hunt        <= '0;
      r_bitcnt      <= '0;
      r_byte_cnt    <= '0;
      r_fas_idx     <= '0;
      r_fas_busy    <= 1'b0;
      r_bip         <= '0;
      r_match       <= 1'b0;
      r_tx_cnt      <= '0;
      r_data        <= '0;
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_good  <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_tx_ack      <= 1'b1;
      r_locked      <= 1'b0;
    end else begin
      r_data_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_good  <= 1'b0;
      r_frame_bad   <= 1'b0;
      r_locked      <= (w_state_next != ST_HUNT);
      r_tx_ack      <= w_tx_ack_next;

      // Clearing on re-entry to HUNT stops leftover frame bits from re-matching.
      if ((w_state_next == ST_HUNT) && (r_state != ST_HUNT)) begin
        r_hunt <= '0;
      end else if (w_strobe && ((r_state == ST_HUNT) || (r_state == ST_RECEIVE))) begin
        r_hunt <= w_hunt_shift;
      end

      if (w_fas_hit) begin
        r_fas_busy    <= 1'b1;
        r_fas_idx     <= 3'd1;
        r_data        <= fas_byte(3'd0);
        r_data_valid  <= 1'b1;
        r_frame_start <= 1'b1;
        r_byte_cnt    <= 13'd6;
        r_bitcnt      <= '0;
        r_bip         <= '0;
      end else if (r_fas_busy) begin
        r_data       <= fas_byte(r_fas_idx);
        r_data_valid <= 1'b1;
        r_fas_idx    <= r_fas_idx + 3'd1;
        if (r_fas_idx == C_FAS_LAST) begin
          r_fas_busy <= 1'b0;
        end
      end

      if ((r_state == ST_RECEIVE) && w_strobe) begin
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (w_byte_done) begin
        r_data       <= w_byte;
        r_data_valid <= 1'b1;
        if (w_last_byte) begin
          r_match <= (w_byte == r_bip);
        end else begin
          r_bip      <= r_bip ^ w_byte;
          r_byte_cnt <= r_byte_cnt + 13'd1;
        end
      end

      if (r_state == ST_CHECK) begin
        r_frame_good <= r_match;
        r_frame_bad  <= !r_match;
        r_tx_cnt     <= '0;
      end else if (w_in_ack && i_sclk_en_16_x_baud) begin
        r_tx_cnt <= (r_tx_cnt == C_TX_LAST) ? '0 : r_tx_cnt + 1'b1;
      end
    end
  end

  assign o_data        = r_data;
  assign o_data_valid  = r_data_valid;
  assign o_frame_start = r_frame_start;
  assign o_frame_good  = r_frame_good;
  assign o_frame_bad   = r_frame_bad;
  assign o_otn_tx_ack  = r_tx_ack;
  assign o_locked      = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_frame_rx_ack.sv
// +----------------------------------------------------------------------+
// | tb_frame_rx_ack : scoreboard bench for frame_rx_ack (short frames).   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_frame_rx_ack;

  localparam int FL = 24;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rx;
  logic       arq;
  logic [7:0] o_data;
  logic       o_data_valid;
  logic       o_frame_start;
  logic       o_frame_good;
  logic       o_frame_bad;
  logic       o_otn_tx_ack;
  logic       o_locked;

  int n_checks = 0;
  int n_pass   = 0;
  bit ack_ignore = 1'b0;

  logic [8:0]  exp_q[$];
  bit          res_q[$];
  logic [12:0] ack_q[$];

  logic [7:0] fas_b [6] = '{8'hF6, 8'hF6, 8'hF6, 8'h28, 8'h28, 8'h28};
  logic [7:0] fr [FL];

  frame_rx_ack #(
    .FRAME_LEN (FL),
    .BAUD_DIV  (BD)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_sclk_en_16_x_baud (en),
    .i_otn_rx_data       (rx),
    .i_arq_en            (arq),
    .o_data              (o_data),
    .o_data_valid        (o_data_valid),
    .o_frame_start       (o_frame_start),
    .o_frame_good        (o_frame_good),
    .o_frame_bad         (o_frame_bad),
    .o_otn_tx_ack        (o_otn_tx_ack),
    .o_locked            (o_locked)
  );

  initial forever #5 clk = ~clk;

  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      en = ~en;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [12:0] ack_wave(input bit good);
    return {1'b1, 4'b0000, {4{good}}, 4'b0000};
  endfunction

  task automatic send_bit(input logic b);
    rx = b;
    repeat (2 * BD) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) send_bit(b[j]);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) send_bit(1'b1);
  endtask

  task automatic build(input bit with_fas);
    logic [7:0] bip;
    for (int i = 0; i < FL; i++) fr[i] = (i < 6) ? fas_b[i] : 8'(i - 6);
    if (with_fas) for (int i = 0; i < 6; i++) fr[8 + i] = fas_b[i];
    bip = 8'h00;
    for (int i = 6; i < FL - 1; i++) bip = bip ^ fr[i];
    fr[FL - 1] = bip;
  endtask

  // corrupt_idx < 0: clean; abort_at >= 0: stop mid-byte with no result expected
  task automatic send_frame(input int corrupt_idx, input bit ack_exp,
                            input int abort_at, input int arq_on_at);
    logic [7:0] b;
    bit good;
    good = (corrupt_idx < 0);
    if (abort_at < 0) begin
      res_q.push_back(good);
      if (ack_exp) ack_q.push_back(ack_wave(good));
    end
    for (int i = 0; i < FL; i++) begin
      if (i == arq_on_at) arq = 1'b1;
      b = fr[i];
      if (i == corrupt_idx) b = b ^ 8'h04;
      if (i == abort_at) begin
        for (int j = 0; j < 4; j++) send_bit(b[j]);
        return;
      end
      exp_q.push_back({(i == 0), b});
      send_byte(b);
    end
  endtask

  // Byte / frame-start and result monitor
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (o_data_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("data_unexpected", {23'd0, o_frame_start, o_data}, 32'hFFFF_FFFF);
        else chk("data_byte", {23'd0, o_frame_start, o_data}, {23'd0, exp_q.pop_front()});
      end else if (o_frame_start === 1'b1) begin
        chk("start_without_valid", 32'(o_frame_start), 32'd0);
      end
      if ((o_frame_good | o_frame_bad) === 1'b1) begin
        if (res_q.size() == 0) chk("result_unexpected", {30'd0, o_frame_good, o_frame_bad}, 32'hFFFF_FFFF);
        else chk("frame_result", {30'd0, o_frame_good, o_frame_bad},
                 res_q.pop_front() ? 32'd2 : 32'd1);
      end
    end
  end

  // ACK line monitor: one sample per enable from the first low sample
  initial begin
    logic [12:0] wave;
    int n;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && en && (o_otn_tx_ack === 1'b0) && !ack_ignore) begin
        n = 0;
        wave = '0;
        while (n < 13) begin
          if (en) begin
            wave[n] = o_otn_tx_ack;
            n++;
          end
          if (n < 13) begin
            @(posedge clk);
            #1;
          end
        end
        if (ack_q.size() == 0) chk("ack_unexpected", {19'd0, wave}, 32'hFFFF_FFFF);
        else chk("ack_wave", {19'd0, wave}, {19'd0, ack_q.pop_front()});
      end
    end
  end

  initial begin
    int t;
    rst = 1'b1;
    rx  = 1'b1;
    arq = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    chk("rst_data",   32'(o_data), 32'd0);
    chk("rst_valid",  32'(o_data_valid), 32'd0);
    chk("rst_start",  32'(o_frame_start), 32'd0);
    chk("rst_good",   32'(o_frame_good), 32'd0);
    chk("rst_bad",    32'(o_frame_bad), 32'd0);
    chk("rst_ack",    32'(o_otn_tx_ack), 32'd1);
    chk("rst_locked", 32'(o_locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(4);

    // Clean frame with ACK, then a corrupted one
    build(1'b0);
    send_frame(-1, 1'b1, -1, -1);
    idle(10);
    send_frame(10, 1'b1, -1, -1);
    idle(10);

    // Clean frame, ACK disabled
    arq = 1'b0;
    send_frame(-1, 1'b0, -1, -1);
    idle(10);
    chk("locked_after_noarq", 32'(o_locked), 32'd0);
    chk("ack_idle_noarq", 32'(o_otn_tx_ack), 32'd1);

    // Random prefix, then a frame carrying the FAS inside its payload
    for (int i = 0; i < 37; i++) send_bit(1'($urandom_range(0, 1)));
    build(1'b1);
    send_frame(-1, 1'b0, -1, -1);
    idle(10);
    build(1'b0);

    // Reset in the middle of byte 12
    arq = 1'b1;
    send_frame(-1, 1'b1, 12, -1);
    chk("locked_midframe", 32'(o_locked), 32'd1);
    chk("bytes_before_abort", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ack",    32'(o_otn_tx_ack), 32'd1);
    chk("abort_locked", 32'(o_locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);

    // Bad frame, reset while the ACK bit (low) is on the line
    ack_ignore = 1'b1;
    send_frame(10, 1'b0, -1, -1);
    t = 0;
    while ((o_otn_tx_ack !== 1'b0) && (t < 400)) begin
      @(negedge clk);
      t++;
    end
    chk("ack_start_seen", 32'(t < 400), 32'd1);
    repeat (2 * BD + 4) @(negedge clk);
    chk("ack_bit_low", 32'(o_otn_tx_ack), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("ackrst_ack",    32'(o_otn_tx_ack), 32'd1);
    chk("ackrst_locked", 32'(o_locked), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(10);
    ack_ignore = 1'b0;

    // ACK enable raised mid-frame still takes effect at the check
    arq = 1'b0;
    send_frame(-1, 1'b1, -1, 10);
    idle(10);

    repeat (20) @(negedge clk);
    chk("data_drained",   32'(exp_q.size()), 32'd0);
    chk("result_drained", 32'(res_q.size()), 32'd0);
    chk("ack_drained",    32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
